// File: rtl/conv_sched.sv
// conv_sched: walks oc/oy/ox/ic across a 3x3 conv layer and issues window loads, engine starts and partial results.
// Each window takes at least 5 cycles. The result is held stable until res_ready, and the walk stalls while it waits.
module conv_sched #(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 8,
    parameter int CH_W   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic [DIM_W-1:0]  cfg_in_w,
    input  logic [DIM_W-1:0]  cfg_in_h,
    input  logic [CH_W-1:0]   cfg_in_ch,
    input  logic [CH_W-1:0]   cfg_out_ch,
    input  logic [1:0]        cfg_stride,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic              ld_req,
    output logic [ADDR_W-1:0] ld_img_addr,
    output logic [ADDR_W-1:0] ld_wt_addr,
    input  logic              ld_ack,
    output logic              eng_start,
    input  logic              eng_done,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ADDR_W-1:0] res_addr,
    output logic              res_first,
    output logic              res_last
);
    typedef enum logic [2:0] {IDLE, SETUP, LOAD, RUN, WAIT, EMIT, NEXT, DONE} state_t;
    state_t state;

    logic [DIM_W-1:0]  in_w, in_h, out_w, out_h, ox, oy;
    logic [CH_W-1:0]   in_ch, out_ch, ic, oc;
    logic [1:0]        stride;
    logic [ADDR_W-1:0] plane, row_step, row_ptr, col_ptr, img_ptr, wt_base, wt_ptr, res_ptr;

    logic cfg_ok, ic_last, ox_last, oy_last, oc_last;
    logic [ADDR_W-1:0] col_step, nine;

    assign cfg_ok  = (in_w >= DIM_W'(3)) && (in_h >= DIM_W'(3)) && (in_ch != '0) &&
                     (out_ch != '0) && ((stride == 2'd1) || (stride == 2'd2));
    assign ic_last = (ic == in_ch - CH_W'(1));
    assign ox_last = (ox == out_w - DIM_W'(1));
    assign oy_last = (oy == out_h - DIM_W'(1));
    assign oc_last = (oc == out_ch - CH_W'(1));
    assign col_step = ADDR_W'(stride);
    assign nine     = ADDR_W'(9);

    assign ld_img_addr = img_ptr;
    assign ld_wt_addr  = wt_ptr;
    assign res_addr    = res_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            ld_req    <= 1'b0;
            eng_start <= 1'b0;
            res_valid <= 1'b0;
            res_first <= 1'b0;
            res_last  <= 1'b0;
            in_w      <= '0;
            in_h      <= '0;
            in_ch     <= '0;
            out_ch    <= '0;
            stride    <= '0;
            out_w     <= '0;
            out_h     <= '0;
            plane     <= '0;
            row_step  <= '0;
            ox        <= '0;
            oy        <= '0;
            ic        <= '0;
            oc        <= '0;
            row_ptr   <= '0;
            col_ptr   <= '0;
            img_ptr   <= '0;
            wt_base   <= '0;
            wt_ptr    <= '0;
            res_ptr   <= '0;
        end else begin
            case (state)
                IDLE: if (cfg_start) begin
                    in_w    <= cfg_in_w;
                    in_h    <= cfg_in_h;
                    in_ch   <= cfg_in_ch;
                    out_ch  <= cfg_out_ch;
                    stride  <= cfg_stride;
                    cfg_err <= 1'b0;
                    busy    <= 1'b1;
                    state   <= SETUP;
                end
                SETUP: begin
                    out_w    <= (stride == 2'd2) ? ((in_w - DIM_W'(3)) >> 1) + DIM_W'(1) : in_w - DIM_W'(2);
                    out_h    <= (stride == 2'd2) ? ((in_h - DIM_W'(3)) >> 1) + DIM_W'(1) : in_h - DIM_W'(2);
                    plane    <= ADDR_W'(in_w) * ADDR_W'(in_h);
                    row_step <= (stride == 2'd2) ? (ADDR_W'(in_w) << 1) : ADDR_W'(in_w);
                    ox       <= '0;
                    oy       <= '0;
                    ic       <= '0;
                    oc       <= '0;
                    row_ptr  <= '0;
                    col_ptr  <= '0;
                    img_ptr  <= '0;
                    wt_base  <= '0;
                    wt_ptr   <= '0;
                    res_ptr  <= '0;
                    if (cfg_ok) begin
                        ld_req <= 1'b1;
                        state  <= LOAD;
                    end else begin
                        cfg_err <= 1'b1;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                LOAD: if (ld_ack) begin
                    ld_req    <= 1'b0;
                    eng_start <= 1'b1;
                    state     <= RUN;
                end
                RUN: begin
                    eng_start <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: if (eng_done) begin
                    res_valid <= 1'b1;
                    res_first <= (ic == '0);
                    res_last  <= ic_last;
                    state     <= EMIT;
                end
                EMIT: if (res_ready) begin
                    res_valid <= 1'b0;
                    res_first <= 1'b0;
                    res_last  <= 1'b0;
                    state     <= NEXT;
                end
                NEXT: begin
                    // ic steps through channel planes; any outer step restarts the channel walk at the new window.
                    if (!ic_last) begin
                        ic      <= ic + CH_W'(1);
                        img_ptr <= img_ptr + plane;
                        wt_ptr  <= wt_ptr + nine;
                    end else begin
                        ic      <= '0;
                        res_ptr <= res_ptr + ADDR_W'(1);
                        if (!ox_last) begin
                            ox      <= ox + DIM_W'(1);
                            col_ptr <= col_ptr + col_step;
                            img_ptr <= col_ptr + col_step;
                            wt_ptr  <= wt_base;
                        end else begin
                            ox <= '0;
                            if (!oy_last) begin
                                oy      <= oy + DIM_W'(1);
                                row_ptr <= row_ptr + row_step;
                                col_ptr <= row_ptr + row_step;
                                img_ptr <= row_ptr + row_step;
                                wt_ptr  <= wt_base;
                            end else begin
                                oy      <= '0;
                                row_ptr <= '0;
                                col_ptr <= '0;
                                img_ptr <= '0;
                                if (!oc_last) begin
                                    oc      <= oc + CH_W'(1);
                                    wt_base <= wt_ptr + nine;
                                    wt_ptr  <= wt_ptr + nine;
                                end
                            end
                        end
                    end
                    if (ic_last && ox_last && oy_last && oc_last) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        ld_req <= 1'b1;
                        state  <= LOAD;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_sched.sv
// Directed bench for conv_sched: a table of layer configs with hand-computed window sequences, plus stall and reset sequences.
module tb_conv_sched;
    localparam int ADDR_W = 16;
    localparam int DIM_W  = 8;
    localparam int CH_W   = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_start = 1'b0;
    logic [DIM_W-1:0]  cfg_in_w = '0;
    logic [DIM_W-1:0]  cfg_in_h = '0;
    logic [CH_W-1:0]   cfg_in_ch = '0;
    logic [CH_W-1:0]   cfg_out_ch = '0;
    logic [1:0]        cfg_stride = '0;
    logic              busy, done, cfg_err, ld_req, eng_start, res_valid, res_first, res_last;
    logic [ADDR_W-1:0] ld_img_addr, ld_wt_addr, res_addr;
    logic              ld_ack = 1'b0;
    logic              eng_done = 1'b0;
    logic              res_ready = 1'b0;

    conv_sched #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .CH_W(CH_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start),
        .cfg_in_w(cfg_in_w), .cfg_in_h(cfg_in_h), .cfg_in_ch(cfg_in_ch),
        .cfg_out_ch(cfg_out_ch), .cfg_stride(cfg_stride),
        .busy(busy), .done(done), .cfg_err(cfg_err),
        .ld_req(ld_req), .ld_img_addr(ld_img_addr), .ld_wt_addr(ld_wt_addr), .ld_ack(ld_ack),
        .eng_start(eng_start), .eng_done(eng_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_addr(res_addr),
        .res_first(res_first), .res_last(res_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] img;
        logic [15:0] wt;
        logic [15:0] res;
        logic        first;
        logic        last;
    } win_t;

    typedef struct {
        int in_w;
        int in_h;
        int in_ch;
        int out_ch;
        int stride;
        bit err;
        int base;
        int n;
    } case_t;

    localparam int NCASE = 11;
    case_t cases[NCASE];
    win_t  exp_win[$];
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic void set_case(input int k, input int w, input int h, input int ic,
                                     input int oc, input int s, input bit err, input int n);
        cases[k].in_w = w;   cases[k].in_h = h;
        cases[k].in_ch = ic; cases[k].out_ch = oc;
        cases[k].stride = s; cases[k].err = err;
        cases[k].base = exp_win.size();
        cases[k].n = n;
    endfunction

    function automatic void add(input int img, input int wt, input int res, input bit f, input bit l);
        win_t w;
        w.img = 16'(img); w.wt = 16'(wt); w.res = 16'(res); w.first = f; w.last = l;
        exp_win.push_back(w);
    endfunction

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_err"}, int'(cfg_err), 0);
        chk({tag, "_ld_req"}, int'(ld_req), 0);
        chk({tag, "_eng_start"}, int'(eng_start), 0);
        chk({tag, "_res_valid"}, int'(res_valid), 0);
        chk({tag, "_res_addr"}, int'(res_addr), 0);
        chk({tag, "_img_addr"}, int'(ld_img_addr), 0);
    endtask

    // Runs one table entry with immediate handshakes; optional 5-cycle res_ready stall and mid-layer cfg_start.
    task automatic run_case(input int k, input bit stall, input bit poke);
        case_t c;
        win_t  cur;
        int    widx, cyc, ld_cnt, es_cnt, stall_cnt, exp_done_cyc;
        bit    prev_es, seen, drop_pending, fin;
        c = cases[k];
        cfg_in_w   = DIM_W'(c.in_w);
        cfg_in_h   = DIM_W'(c.in_h);
        cfg_in_ch  = CH_W'(c.in_ch);
        cfg_out_ch = CH_W'(c.out_ch);
        cfg_stride = 2'(c.stride);
        cfg_start  = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        chk($sformatf("c%0d_busy_on_start", k), int'(busy), 1);
        chk($sformatf("c%0d_err_cleared", k), int'(cfg_err), 0);
        widx = 0; cyc = 0; ld_cnt = 0; es_cnt = 0; stall_cnt = 0;
        prev_es = 0; seen = 0; drop_pending = 0; fin = 0; cur = '0;
        exp_done_cyc = 1 + 5 * c.n + (stall ? 5 : 0);
        while (!fin && cyc < 2000) begin
            ld_ack   = ld_req;
            eng_done = prev_es;
            prev_es  = eng_start;
            if (ld_req) ld_cnt++;
            if (eng_start) es_cnt++;
            if (drop_pending) begin
                chk($sformatf("c%0d_res_valid_drop", k), int'(res_valid), 0);
                drop_pending = 0;
            end
            res_ready = 1'b0;
            if (res_valid) begin
                if (!seen) begin
                    cur = (widx < c.n) ? exp_win[c.base + widx] : '0;
                    chk($sformatf("c%0d_w%0d_img", k, widx), int'(ld_img_addr), int'(cur.img));
                    chk($sformatf("c%0d_w%0d_wt", k, widx), int'(ld_wt_addr), int'(cur.wt));
                    chk($sformatf("c%0d_w%0d_res", k, widx), int'(res_addr), int'(cur.res));
                    chk($sformatf("c%0d_w%0d_first", k, widx), int'(res_first), int'(cur.first));
                    chk($sformatf("c%0d_w%0d_last", k, widx), int'(res_last), int'(cur.last));
                    seen = 1;
                    stall_cnt = (stall && widx == 0) ? 5 : 0;
                    if (poke && widx == 1) begin
                        cfg_in_w = 8'd2; cfg_stride = 2'd3; cfg_out_ch = 10'd7; cfg_start = 1'b1;
                    end
                end else begin
                    chk($sformatf("c%0d_stall_res_addr", k), int'(res_addr), int'(cur.res));
                    chk($sformatf("c%0d_stall_img", k), int'(ld_img_addr), int'(cur.img));
                    chk($sformatf("c%0d_stall_first", k), int'(res_first), int'(cur.first));
                    chk($sformatf("c%0d_stall_ld_req", k), int'(ld_req), 0);
                end
                if (stall_cnt == 0) begin
                    res_ready = 1'b1;
                    drop_pending = 1;
                    seen = 0;
                    widx++;
                end else begin
                    stall_cnt--;
                end
            end
            if (done) begin
                chk($sformatf("c%0d_cfg_err", k), int'(cfg_err), int'(c.err));
                chk($sformatf("c%0d_done_cycle", k), cyc, exp_done_cyc);
                fin = 1;
            end
            @(posedge clk); #1;
            cfg_start = 1'b0;
            cyc++;
        end
        ld_ack = 1'b0; eng_done = 1'b0; res_ready = 1'b0;
        if (!fin) chk($sformatf("c%0d_done_timeout", k), 0, 1);
        chk($sformatf("c%0d_windows", k), widx, c.n);
        chk($sformatf("c%0d_eng_starts", k), es_cnt, c.n);
        if (c.err) chk($sformatf("c%0d_err_ld_req", k), ld_cnt, 0);
        chk($sformatf("c%0d_done_pulse", k), int'(done), 0);
        chk($sformatf("c%0d_busy_after", k), int'(busy), 0);
        chk($sformatf("c%0d_err_sticky", k), int'(cfg_err), int'(c.err));
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int bimg[8];
        int eimg[3];
        int cyc;
        bit got;
        bimg = '{0, 25, 2, 27, 10, 35, 12, 37};
        eimg = '{0, 16, 32};

        set_case(0, 3, 3, 1, 1, 1, 1'b0, 1);
        add(0, 0, 0, 1, 1);
        set_case(1, 2, 5, 1, 1, 1, 1'b1, 0);
        set_case(2, 5, 5, 2, 1, 2, 1'b0, 8);
        for (int i = 0; i < 8; i++) add(bimg[i], (i % 2) * 9, i / 2, (i % 2) == 0, (i % 2) == 1);
        set_case(3, 5, 5, 1, 1, 3, 1'b1, 0);
        set_case(4, 5, 5, 2, 2, 2, 1'b0, 16);
        for (int i = 0; i < 16; i++)
            add(bimg[i % 8], (i % 2) * 9 + (i / 8) * 18, i / 2, (i % 2) == 0, (i % 2) == 1);
        set_case(5, 4, 3, 1, 1, 1, 1'b0, 2);
        add(0, 0, 0, 1, 1);
        add(1, 0, 1, 1, 1);
        set_case(6, 4, 4, 3, 2, 2, 1'b0, 6);
        for (int i = 0; i < 6; i++) add(eimg[i % 3], (i / 3) * 27 + (i % 3) * 9, i / 3, (i % 3) == 0, (i % 3) == 2);
        set_case(7, 5, 5, 0, 1, 1, 1'b1, 0);
        set_case(8, 5, 5, 1, 0, 1, 1'b1, 0);
        set_case(9, 5, 5, 1, 1, 0, 1'b1, 0);
        set_case(10, 5, 2, 1, 1, 1, 1'b1, 0);

        #1;
        chk_outputs_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk_outputs_zero("idle");

        for (int k = 0; k < NCASE; k++) run_case(k, 1'b0, (k == 4));
        run_case(2, 1'b1, 1'b0);

        // Abort in WAIT: reset must clear outputs at once and no done may follow.
        cfg_in_w = 8'd3; cfg_in_h = 8'd3; cfg_in_ch = 10'd1; cfg_out_ch = 10'd1; cfg_stride = 2'd1;
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        got = 0;
        cyc = 0;
        while (!got && cyc < 50) begin
            ld_ack = ld_req;
            if (eng_start) got = 1;
            @(posedge clk); #1;
            cyc++;
        end
        ld_ack = 1'b0;
        chk("rst_reached_wait", int'(got), 1);
        chk("rst_busy_in_wait", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("rst_abort");
        eng_done = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        eng_done = 1'b0;
        rst_n = 1'b1;
        got = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done || busy || res_valid) got = 1;
        end
        chk("rst_no_done_or_activity", int'(got), 0);
        run_case(0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
